// File: rtl/yutorina_bus_ram_slave_pkg.sv
// Shared bus-slave definitions: active-low strobe levels, the read/write flag
// and the slave state encodings used by the RAM responder.
package yutorina_bus_ram_slave_pkg;

  localparam int WORD_DATA_W = 32;
  typedef logic [WORD_DATA_W-1:0] word_data_bus_t;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;
  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;
  localparam word_data_bus_t ZERO = '0;

  typedef enum logic [1:0] {
    SLAVE_IDLE  = 2'h0,
    SLAVE_WAIT  = 2'h1,
    SLAVE_READY = 2'h2
  } slave_state_t;

endpackage

// File: rtl/yutorina_ram_array.sv
// Single-port synchronous RAM with a registered read port and write-first
// behaviour (a write also presents the new word on r_data).
module yutorina_ram_array #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] w_data,
  output logic [DATA_W-1:0] r_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= w_data;
      r_data    <= w_data;
    end else begin
      r_data    <= mem[addr];
    end
  end

endmodule

// File: rtl/yutorina_bus_ram_slave.sv
// Bus RAM responder: accepts a strobed request, waits WAIT_CYCLES, then
// performs the access and answers with a one-cycle active-low ready pulse.
module yutorina_bus_ram_slave
  import yutorina_bus_ram_slave_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = WORD_DATA_W,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_,
  input  logic              as_,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] w_data,
  output logic              rdy_,
  output logic [DATA_W-1:0] r_data
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  slave_state_t      state_reg, state_next;
  logic [3:0]        count_reg, count_next;
  logic [ADDR_W-1:0] addr_reg;
  logic              rw_reg;
  logic [DATA_W-1:0] w_data_reg;
  logic              rdy_reg;
  logic              rd_valid_reg;
  logic              req;
  logic              idle;
  logic              enter_ready;
  logic [ADDR_W-1:0] op_addr;
  logic              op_rw;
  logic [DATA_W-1:0] op_w_data;
  logic              ram_we;
  logic [DATA_W-1:0] ram_r_data;

  assign req  = (cs_ == ENABLE_) && (as_ == ENABLE_);
  assign idle = (state_reg == SLAVE_IDLE);

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    enter_ready = 1'b0;
    unique case (state_reg)
      SLAVE_IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_next  = SLAVE_READY;
            enter_ready = 1'b1;
          end else begin
            state_next = SLAVE_WAIT;
            count_next = WAIT_LOAD;
          end
        end
      end
      SLAVE_WAIT: begin
        // A dropped strobe or chip select abandons the request
        if (!req) begin
          state_next = SLAVE_IDLE;
        end else if (count_reg == 4'd0) begin
          state_next  = SLAVE_READY;
          enter_ready = 1'b1;
        end else begin
          count_next = count_reg - 4'd1;
        end
      end
      SLAVE_READY: state_next = SLAVE_IDLE;
      default:     state_next = SLAVE_IDLE;
    endcase
  end

  // Zero wait states complete on the accepting edge, so use the live bus then
  assign op_addr   = idle ? addr   : addr_reg;
  assign op_rw     = idle ? rw     : rw_reg;
  assign op_w_data = idle ? w_data : w_data_reg;
  assign ram_we    = enter_ready && (op_rw == WRITE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= SLAVE_IDLE;
      count_reg    <= 4'd0;
      rdy_reg      <= DISABLE_;
      rd_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      rdy_reg      <= enter_ready ? ENABLE_ : DISABLE_;
      rd_valid_reg <= enter_ready && (op_rw == READ);
    end
  end

  always_ff @(posedge clk) begin
    if (idle && req) begin
      addr_reg   <= addr;
      rw_reg     <= rw;
      w_data_reg <= w_data;
    end
  end

  yutorina_ram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk    (clk),
    .we     (ram_we),
    .addr   (op_addr),
    .w_data (op_w_data),
    .r_data (ram_r_data)
  );

  assign rdy_   = rdy_reg;
  assign r_data = rd_valid_reg ? ram_r_data : '0;

endmodule

// File: tb/tb_yutorina_bus_ram_slave.sv
// Bench for yutorina_bus_ram_slave: three instances (1, 0 and 3 wait states)
// driven by directed and random transactions against a word-array model.
module tb_yutorina_bus_ram_slave;
  import yutorina_bus_ram_slave_pkg::*;

  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_a  [3];
  logic          cs_a   [3];
  logic          as_a   [3];
  logic          rw_a   [3];
  logic [AW-1:0] addr_a [3];
  logic [DW-1:0] wd_a   [3];
  logic          rdy_a  [3];
  logic [DW-1:0] rd_a   [3];

  int checks = 0;
  int errors = 0;
  int wc_of [3] = '{1, 0, 3};

  logic [DW-1:0] model_mem   [3][2**AW];
  bit            model_valid [3][2**AW];

  always #5 clk = ~clk;

  yutorina_bus_ram_slave #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst_a[0]), .cs_(cs_a[0]), .as_(as_a[0]), .rw(rw_a[0]),
    .addr(addr_a[0]), .w_data(wd_a[0]), .rdy_(rdy_a[0]), .r_data(rd_a[0]));
  yutorina_bus_ram_slave #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst_a[1]), .cs_(cs_a[1]), .as_(as_a[1]), .rw(rw_a[1]),
    .addr(addr_a[1]), .w_data(wd_a[1]), .rdy_(rdy_a[1]), .r_data(rd_a[1]));
  yutorina_bus_ram_slave #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst_a[2]), .cs_(cs_a[2]), .as_(as_a[2]), .rw(rw_a[2]),
    .addr(addr_a[2]), .w_data(wd_a[2]), .rdy_(rdy_a[2]), .r_data(rd_a[2]));

  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(string tag, int d, logic exp_rdy, logic [DW-1:0] exp_rd);
    chk($sformatf("%s dut%0d rdy_", tag, d), {{(DW-1){1'b0}}, rdy_a[d]}, {{(DW-1){1'b0}}, exp_rdy});
    chk($sformatf("%s dut%0d r_data", tag, d), rd_a[d], exp_rd);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic release_bus(int d);
    cs_a[d] = 1'b1;
    as_a[d] = 1'b1;
  endtask

  task automatic issue(int d, logic rwv, logic [AW-1:0] a, logic [DW-1:0] wd);
    cs_a[d]   = 1'b0;
    as_a[d]   = 1'b0;
    rw_a[d]   = rwv;
    addr_a[d] = a;
    wd_a[d]   = wd;
  endtask

  // Full transaction: ready must pulse low for exactly the wc-th cycle after acceptance
  task automatic txn(int d, logic rwv, logic [AW-1:0] a, logic [DW-1:0] wd, string tag);
    logic [DW-1:0] exp_rd;
    bit known;
    int wc;
    wc     = wc_of[d];
    known  = (rwv == WRITE) || model_valid[d][a];
    exp_rd = (rwv == READ) ? model_mem[d][a] : '0;
    issue(d, rwv, a, wd);
    for (int j = 0; j <= wc + 1; j++) begin
      step();
      chk($sformatf("%s dut%0d rdy_ cyc%0d", tag, d, j),
          {{(DW-1){1'b0}}, rdy_a[d]}, (j == wc) ? 32'd0 : 32'd1);
      if (j != wc || known)
        chk($sformatf("%s dut%0d r_data cyc%0d", tag, d, j), rd_a[d], (j == wc) ? exp_rd : 32'd0);
      if (j < wc) begin
        addr_a[d] = AW'($urandom);
        wd_a[d]   = $urandom;
        rw_a[d]   = 1'($urandom);
      end else begin
        release_bus(d);
      end
    end
    if (rwv == WRITE) begin
      model_mem[d][a]   = wd;
      model_valid[d][a] = 1'b1;
    end
    $display("txn %s dut%0d %s addr=0x%03h data=0x%08h", tag, d,
             (rwv == READ) ? "read " : "write", a, (rwv == READ) ? exp_rd : wd);
  endtask

  task automatic reset_with_strobe(string tag);
    for (int d = 0; d < 3; d++) begin
      rst_a[d] = 1'b1;
      issue(d, WRITE, 12'h000, 32'hBAD0_BAD0);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      for (int d = 0; d < 3; d++) chk_bus($sformatf("%s cyc%0d", tag, k), d, 1'b1, 32'd0);
    end
    for (int d = 0; d < 3; d++) begin
      rst_a[d] = 1'b0;
      release_bus(d);
    end
    step();
    $display("txn %s reset held 2 cycles with strobe asserted", tag);
  endtask

  initial begin
    logic [DW-1:0] wd;
    logic [DW-1:0] old;
    logic [AW-1:0] pool [8];
    int d;
    logic [AW-1:0] a;
    logic rwv;

    pool = '{12'h000, 12'h005, 12'h010, 12'h020, 12'h033, 12'h100, 12'h7A1, 12'hFFF};

    reset_with_strobe("reset");

    // Seed mem[0], then reset with a write strobe active: the word must survive
    txn(0, WRITE, 12'h000, 32'h5A5A_5A5A, "seed0");
    txn(1, WRITE, 12'h000, 32'h3C3C_3C3C, "seed0");
    reset_with_strobe("reset2");
    txn(0, READ, 12'h000, 32'h0, "rst_nowrite");
    txn(1, READ, 12'h000, 32'h0, "rst_nowrite");

    txn(0, WRITE, 12'h005, 32'hDEAD_BEEF, "wr_w1");
    txn(0, READ,  12'h005, 32'h0,         "rd_w1");

    txn(1, WRITE, 12'h000, 32'h0000_0001, "wr_w0");
    txn(1, READ,  12'h000, 32'h0,         "rd_w0");

    // Abort after one WAIT cycle
    txn(2, WRITE, 12'h010, 32'hCAFE_F00D, "abort_prior");
    issue(2, WRITE, 12'h010, 32'h1234_5678);
    step();
    chk_bus("abort acc", 2, 1'b1, 32'd0);
    step();
    chk_bus("abort wait", 2, 1'b1, 32'd0);
    as_a[2] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_bus($sformatf("abort post%0d", k), 2, 1'b1, 32'd0);
    end
    release_bus(2);
    $display("txn abort dut2 write addr=0x010 data=0x12345678 abandoned");
    txn(2, READ, 12'h010, 32'h0, "abort_rd");

    // Strobe without chip select
    cs_a[0] = 1'b1; as_a[0] = 1'b0; rw_a[0] = WRITE; addr_a[0] = 12'h005; wd_a[0] = $urandom;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_bus($sformatf("cs_gate cyc%0d", k), 0, 1'b1, 32'd0);
    end
    release_bus(0);
    $display("txn cs_gate dut0 strobe with cs_=1 for 5 cycles");
    txn(0, READ, 12'h005, 32'h0, "cs_gate_rd");

    // Back-to-back: strobe held through READY, second request is a read-back
    wd = $urandom;
    issue(0, WRITE, 12'h033, wd);
    step();
    chk_bus("b2b acc", 0, 1'b1, 32'd0);
    step();
    chk_bus("b2b rdy1", 0, 1'b0, 32'd0);
    issue(0, READ, 12'h033, $urandom);
    step();
    chk_bus("b2b ready_exit", 0, 1'b1, 32'd0);
    step();
    chk_bus("b2b acc2", 0, 1'b1, 32'd0);
    step();
    chk_bus("b2b rdy2", 0, 1'b0, wd);
    release_bus(0);
    step();
    chk_bus("b2b idle", 0, 1'b1, 32'd0);
    model_mem[0][12'h033]   = wd;
    model_valid[0][12'h033] = 1'b1;
    $display("txn b2b dut0 write+read addr=0x033 data=0x%08h", wd);

    // Reset landing on the edge that would have completed a write
    old = $urandom;
    txn(2, WRITE, 12'h020, old, "rstmid_prior");
    issue(2, WRITE, 12'h020, ~old);
    step();
    step();
    step();
    rst_a[2] = 1'b1;
    step();
    chk_bus("rstmid reset", 2, 1'b1, 32'd0);
    rst_a[2] = 1'b0;
    release_bus(2);
    step();
    chk_bus("rstmid idle", 2, 1'b1, 32'd0);
    $display("txn rstmid dut2 write addr=0x020 cancelled by reset");
    txn(2, READ, 12'h020, 32'h0, "rstmid_rd");

    // Random mix over a small address pool
    for (int i = 0; i < 24; i++) begin
      d   = int'($urandom_range(2, 0));
      a   = pool[$urandom_range(7, 0)];
      rwv = model_valid[d][a] ? 1'($urandom) : WRITE;
      txn(d, rwv, a, $urandom, $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
